// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - initiator for a single-port synchronous RAM, narrow/wide requests
module mem_access_unit #(
  parameter int RAM_WIDTH    = 16,
  parameter int RAM_SIZE_LOG = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic                      req_wide_i,
  input  logic [RAM_SIZE_LOG-1:0]   req_addr_i,
  input  logic [2*RAM_WIDTH-1:0]    req_data_i,
  output logic                      resp_valid_o,
  output logic [2*RAM_WIDTH-1:0]    resp_data_o,
  output logic [RAM_SIZE_LOG-1:0]   mem_addr_o,
  output logic [RAM_WIDTH-1:0]      mem_data_o,
  output logic                      mem_we_o,
  input  logic [RAM_WIDTH-1:0]      mem_data_i
);

  localparam logic [RAM_SIZE_LOG-1:0] ADDR_ONE = 1;

  // IDLE: waiting; LO: RAM acts on low word; HI: RAM acts on high word; LAST: response
  typedef enum logic [1:0] {IDLE, LO, HI, LAST} state_t;

  state_t                    state_q, state_d;
  logic                      wide_q, wide_d;
  logic                      we_q, we_d;
  logic [RAM_WIDTH-1:0]      hi_data_q, hi_data_d;
  logic [RAM_SIZE_LOG-1:0]   addr_hi_q, addr_hi_d;
  logic [RAM_SIZE_LOG-1:0]   mem_addr_d;
  logic [RAM_WIDTH-1:0]      mem_data_d;
  logic                      mem_we_d;
  logic                      resp_valid_d;
  logic [2*RAM_WIDTH-1:0]    resp_data_d;

  assign req_ready_o = (state_q == IDLE);

  // Next-state and next values of every registered output and latched request field
  always_comb begin
    state_d      = state_q;
    wide_d       = wide_q;
    we_d         = we_q;
    hi_data_d    = hi_data_q;
    addr_hi_d    = addr_hi_q;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    mem_we_d     = mem_we_o;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_o;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          mem_addr_d = req_addr_i;
          mem_data_d = req_data_i[RAM_WIDTH-1:0];
          mem_we_d   = req_we_i;
          wide_d     = req_wide_i;
          we_d       = req_we_i;
          hi_data_d  = req_data_i[2*RAM_WIDTH-1:RAM_WIDTH];
          // Wraps naturally at the top of the address space
          addr_hi_d  = req_addr_i + ADDR_ONE;
          state_d    = LO;
        end
      end
      LO: begin
        if (wide_q) begin
          mem_addr_d = addr_hi_q;
          mem_data_d = hi_data_q;
          mem_we_d   = we_q;
          state_d    = HI;
        end else begin
          mem_we_d   = 1'b0;
          state_d    = LAST;
        end
      end
      HI: begin
        // RAM output now holds the low word (read data or write echo)
        resp_data_d[RAM_WIDTH-1:0] = mem_data_i;
        mem_we_d                   = 1'b0;
        state_d                    = LAST;
      end
      LAST: begin
        if (wide_q) begin
          resp_data_d[2*RAM_WIDTH-1:RAM_WIDTH] = mem_data_i;
        end else begin
          resp_data_d = {{RAM_WIDTH{1'b0}}, mem_data_i};
        end
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches and registered RAM/response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wide_q       <= 1'b0;
      we_q         <= 1'b0;
      hi_data_q    <= '0;
      addr_hi_q    <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_we_o     <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      wide_q       <= wide_d;
      we_q         <= we_d;
      hi_data_q    <= hi_data_d;
      addr_hi_q    <= addr_hi_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      mem_we_o     <= mem_we_d;
      resp_valid_o <= resp_valid_d;
      resp_data_o  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural RAM
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_wide;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  logic [11:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] ram [0:4095];
  logic        prev_rv = 1'b0;

  mem_access_unit #(.RAM_WIDTH(16), .RAM_SIZE_LOG(12)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_wide_i(req_wide),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_we_o(mem_we),
    .mem_data_i(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM, registered output, echoes written data
  initial for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      check("resp_pulse_width", {31'b0, prev_rv}, 32'd0);
      if (exp_data.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got %h required no response", resp_data);
      end else begin
        check("resp_data", resp_data, exp_data.pop_front());
        check("resp_latency", cyc, exp_cyc.pop_front());
      end
    end
    prev_rv <= (resp_valid === 1'b1);
  end

  // Write monitor: logs every RAM write strobe
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic issue(input logic we, input logic wide, input logic [11:0] addr,
                       input logic [31:0] data, input logic [31:0] exp, input bit keep,
                       output int acc_cyc, output logic rv_at_acc);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_wide = wide; req_addr = addr; req_data = data;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ready=%b required 1", req_ready);
    end
    acc_cyc   = cyc;
    rv_at_acc = resp_valid;
    exp_data.push_back(exp);
    exp_cyc.push_back(cyc + 1 + (wide ? 3 : 2));
    @(posedge clk);
    #1;
    req_addr = 12'($urandom());
    req_data = $urandom();
    req_wide = 1'($urandom());
    req_we   = 1'($urandom());
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (exp_data.size() == 0) break;
    end
    check("drain_pending", exp_data.size(), 0);
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [11:0] a0, input logic [15:0] d0,
                              input logic [11:0] a1, input logic [15:0] d1);
    check({name, "_count"}, wr_addr.size(), n);
    if (wr_addr.size() >= 1 && n >= 1) begin
      check({name, "_addr0"}, {20'b0, wr_addr[0]}, {20'b0, a0});
      check({name, "_data0"}, {16'b0, wr_data[0]}, {16'b0, d0});
    end
    if (wr_addr.size() >= 2 && n >= 2) begin
      check({name, "_addr1"}, {20'b0, wr_addr[1]}, {20'b0, a1});
      check({name, "_data1"}, {16'b0, wr_data[1]}, {16'b0, d1});
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          acc[4];
    int          a;
    logic        rv;
    logic [11:0] b2b_addr[4];
    logic [31:0] b2b_exp[4];

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
    req_addr = '0; req_data = '0;
    #12;
    check("rst_ready",      {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_we",     {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr",   {20'b0, mem_addr}, 32'd0);
    check("rst_mem_data",   {16'b0, mem_wdata}, 32'd0);
    check("rst_resp_data",  resp_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Narrow write 0x010 = 0xBEEF
    issue(1'b1, 1'b0, 12'h010, 32'hFFFF_BEEF, 32'h0000_BEEF, 1'b0, a, rv);
    drain();
    check_writes("nw_write", 1, 12'h010, 16'hBEEF, 12'h000, 16'h0000);

    // Asynchronous reset while in LO of a narrow write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b0; req_addr = 12'h011; req_data = 32'h0000_1234;
    check("abort_ready_before", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_we_in_lo", {31'b0, mem_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_we_drop",    {31'b0, mem_we}, 32'd0);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_ready",      {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("abort_ram_untouched", {16'b0, ram[12'h011]}, 32'd0);
    check_writes("abort_writes", 0, 12'h000, 16'h0000, 12'h000, 16'h0000);

    // Narrow read-back, with ready low through LO and LAST
    issue(1'b0, 1'b0, 12'h010, 32'h0, 32'h0000_BEEF, 1'b0, a, rv);
    @(negedge clk); check("ready_in_lo",   {31'b0, req_ready}, 32'd0);
    @(negedge clk); check("ready_in_last", {31'b0, req_ready}, 32'd0);
    @(negedge clk); check("ready_back",    {31'b0, req_ready}, 32'd1);
    drain();

    // Wide write then wide read
    issue(1'b1, 1'b1, 12'h020, 32'hDEAD_C0FE, 32'hDEAD_C0FE, 1'b0, a, rv);
    drain();
    check("ww_ram_lo", {16'b0, ram[12'h020]}, 32'h0000_C0FE);
    check("ww_ram_hi", {16'b0, ram[12'h021]}, 32'h0000_DEAD);
    check_writes("ww_write", 2, 12'h020, 16'hC0FE, 12'h021, 16'hDEAD);
    issue(1'b0, 1'b1, 12'h020, 32'h0, 32'hDEAD_C0FE, 1'b0, a, rv);
    drain();

    // Address wrap at top of memory
    issue(1'b1, 1'b1, 12'hFFF, 32'hC001_1234, 32'hC001_1234, 1'b0, a, rv);
    drain();
    check("wrap_ram_fff", {16'b0, ram[12'hFFF]}, 32'h0000_1234);
    check("wrap_ram_000", {16'b0, ram[12'h000]}, 32'h0000_C001);
    check_writes("wrap_write", 2, 12'hFFF, 16'h1234, 12'h000, 16'hC001);
    issue(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_C001, 1'b0, a, rv);
    drain();

    // Back-to-back narrow reads with req_valid held high
    b2b_addr = '{12'h010, 12'h020, 12'h021, 12'h000};
    b2b_exp  = '{32'h0000_BEEF, 32'h0000_C0FE, 32'h0000_DEAD, 32'h0000_C001};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, b2b_addr[i], 32'h0, b2b_exp[i], (i < 3), acc[i], rv);
      if (i > 0) begin
        check("b2b_spacing", acc[i] - acc[i-1], 32'd3);
        check("b2b_accept_with_resp", {31'b0, rv}, 32'd1);
      end
    end
    drain();
    check_writes("b2b_writes", 0, 12'h000, 16'h0000, 12'h000, 16'h0000);

    // Stall: fields toggle with req_valid low
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_we = 1'b1; req_wide = 1'($urandom());
      req_addr = 12'($urandom()); req_data = $urandom();
    end
    @(negedge clk); #1;
    check("stall_no_resp_pending", exp_data.size(), 0);
    check("stall_ready", {31'b0, req_ready}, 32'd1);
    check_writes("stall_writes", 0, 12'h000, 16'h0000, 12'h000, 16'h0000);
    issue(1'b0, 1'b0, 12'h021, 32'h0, 32'h0000_DEAD, 1'b0, a, rv);
    drain();
    check_writes("final_writes", 0, 12'h000, 16'h0000, 12'h000, 16'h0000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
